rpn_stack_core: RTL
===================

// Module: rpn_stack_core
// PURPOSE
//  Parametrised RPN evaluation engine for the stack calculator datapath.
//  Takes keypad tokens (digits already assembled by the number builder) over a valid/ready handshake.
//  Holds operands on a DEPTH-entry stack and executes + - * / with an iterative divider.
//  Reports the final answer on '=' and flags overflow, underflow, syntax and divide-by-zero errors.
// PARAMETERS
//  WIDTH  32  operand/result width in bits, unsigned arithmetic, results wrap mod 2^WIDTH
//  DEPTH  8   stack entries (>=2)
// PORTS
//  clk           in   1      system clock; all state changes on rising edge
//  reset_n       in   1      asynchronous, active-low reset
//  clear         in   1      synchronous abort/clear; priority over everything except reset_n
//  tok_valid     in   1      token present
//  tok_ready     out  1      engine accepts token this cycle
//  tok_code      in   4      0..9 = number (value on tok_num), A add, B sub, C mul, D div, E equal, F clear
//  tok_num       in   WIDTH  operand value, used only when tok_code<=9
//  top           out  WIDTH  current top of stack (0 when empty)
//  depth         out  $clog2(DEPTH+1)  entries on stack
//  busy          out  1      operator executing (EXEC or DIV)
//  answer        out  WIDTH  result latched on '='
//  answer_valid  out  1      one-cycle pulse when answer updates
//  done          out  1      high in DONE state
//  err           out  1      high in ERROR state
//  err_code      out  2      01 overflow, 10 underflow, 11 div-by-zero, 00 syntax (sp>1 at '=')
// BEHAVIOUR
//  Reset: all outputs 0 except tok_ready=1; stack pointer 0; state IDLE.
//  States: IDLE, EXEC, DIV, DONE, ERROR. Accept = tok_valid && tok_ready at a rising edge (edge N).
//  tok_ready: 1 in IDLE, DONE and ERROR; 0 in EXEC and DIV.
//  IDLE number token: if depth==DEPTH -> ERROR, err_code=01, stack unchanged.
//    Otherwise push at edge N and stay IDLE, giving back-to-back pushes.
//  IDLE A/B/C/D with depth<2: ERROR, err_code=10, stack unchanged.
//  IDLE A/B/C with depth>=2: edge N pops b=top and a=next into operand regs and enters EXEC.
//    Edge N+1 pushes the result and returns to IDLE, so the result is visible on top after edge N+1.
//  Results: A = a+b, B = a-b, C = low WIDTH bits of a*b. All wrap; no overflow flag for arithmetic.
//  IDLE D, b==0: ERROR, err_code=11; operands are not restored (stack depth already reduced by 2).
//  IDLE D, b!=0: restoring unsigned division, one quotient bit per cycle for WIDTH cycles in DIV.
//    The quotient is pushed one edge later, so it is visible on top after edge N+WIDTH+1.
//  Remainder is discarded.
//  IDLE E: depth==1 -> answer<=top, answer_valid high for the one cycle after edge N, enter DONE.
//    depth==0 -> ERROR, err_code=10. depth>1 -> ERROR, err_code=00.
//  F token (IDLE/DONE/ERROR) or clear=1 (any state, including mid-DIV):
//    next edge sets depth=0, answer=0, err=0, done=0 and enters IDLE. clear wins over a simultaneous token.
//  DONE/ERROR: every non-F token is accepted and dropped; no state change.
//  answer holds its value until clear/F/reset.
//  reset_n low at any time: immediate return to reset values, including mid-division; the divider is discarded.
// TESTING
//  T1 (WIDTH=32) push 7, push 5, A, E:
//     top=12 two edges after A accept; answer=12 with a 1-cycle answer_valid; done=1, depth=1.
//  T2 push 3, push 5, B, E: answer=32'hFFFF_FFFE; C case: push 65536, push 65536, C -> top=0.
//  T3 push 100, push 7, D: busy=1 for 33 cycles with tok_ready=0; top=14, depth=1; E gives answer=14.
//  T4 (DEPTH=8) push 9 numbers: 9th gives err=1, err_code=01, depth=8.
//     Further tokens are ignored; F gives err=0, depth=0, IDLE.
//  T5 push 4, push 0, D: err_code=11. After F, push 1, A: err_code=10.
//     After F, push 1, push 2, E: err_code=00.
//  T6 assert reset_n=0 mid-division (cycle 10 of DIV): outputs are reset values with no clock edge;
//     then assert clear mid-DIV and check depth=0, IDLE one edge later.

Source files
------------

// File: rtl/rpn_stack_core_if.sv
// Token handshake between the number builder and the RPN stack engine.
interface rpn_stack_core_if #(
  parameter int WIDTH = 32
) ();
  logic             tok_valid;
  logic             tok_ready;
  logic [3:0]       tok_code;
  logic [WIDTH-1:0] tok_num;

  modport master (output tok_valid, output tok_code, output tok_num, input tok_ready);
  modport slave  (input tok_valid, input tok_code, input tok_num, output tok_ready);
endinterface

// File: rtl/rpn_stack_core.sv
// RPN evaluation engine: operand stack, + - * and an iterative restoring divider,
// with answer latching on '=' and error reporting.
module rpn_stack_core #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  rpn_stack_core_if.slave            tok,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       busy,
  output logic [WIDTH-1:0]           answer,
  output logic                       answer_valid,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [DW-1:0]    SP_ZERO  = {DW{1'b0}};
  localparam logic [DW-1:0]    SP_ONE   = DW'(1);
  localparam logic [DW-1:0]    SP_TWO   = DW'(2);
  localparam logic [DW-1:0]    SP_FULL  = DW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

  localparam logic [3:0] TK_MAX_NUM = 4'd9;
  localparam logic [3:0] TK_ADD     = 4'hA;
  localparam logic [3:0] TK_SUB     = 4'hB;
  localparam logic [3:0] TK_MUL     = 4'hC;
  localparam logic [3:0] TK_DIV     = 4'hD;
  localparam logic [3:0] TK_EQU     = 4'hE;
  localparam logic [3:0] TK_CLR     = 4'hF;

  // Operator select is the low two bits of the token code (A=10, B=11, C=00).
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;
  localparam logic [1:0] OP_MUL = 2'b00;

  localparam logic [1:0] ERR_SYNTAX = 2'b00;
  localparam logic [1:0] ERR_OVF    = 2'b01;
  localparam logic [1:0] ERR_UNF    = 2'b10;
  localparam logic [1:0] ERR_DIV0   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_DIV   = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [DW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] answer_q, answer_d;
  logic             ans_vld_q, ans_vld_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             accept_s;
  logic             is_num_s;
  logic             do_clear_s;
  logic [AW-1:0]    push_idx_s;
  logic [AW-1:0]    tos_idx_s;
  logic [AW-1:0]    nos_idx_s;
  logic [WIDTH-1:0] tos_s;
  logic [WIDTH-1:0] nos_s;
  logic [WIDTH-1:0] alu_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   diff_s;
  logic             fits_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quo_next_s;

  assign tok.tok_ready = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
  assign accept_s      = tok.tok_valid && tok.tok_ready;
  assign is_num_s      = (tok.tok_code <= TK_MAX_NUM);
  assign do_clear_s    = clear || (accept_s && (tok.tok_code == TK_CLR));

  assign push_idx_s = AW'(sp_q);
  assign tos_idx_s  = AW'(sp_q - SP_ONE);
  assign nos_idx_s  = AW'(sp_q - SP_TWO);
  assign tos_s      = stack_q[tos_idx_s];
  assign nos_s      = stack_q[nos_idx_s];

  assign top          = (sp_q == SP_ZERO) ? W_ZERO : tos_s;
  assign depth        = sp_q;
  assign busy         = (state_q == S_EXEC) || (state_q == S_DIV);
  assign answer       = answer_q;
  assign answer_valid = ans_vld_q;
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERROR);
  assign err_code     = err_code_q;

  // Quotient shifts in where the dividend shifts out of op_a; a clear top bit of diff means no borrow.
  assign rem_shift_s = {rem_q, op_a_q[WIDTH-1]};
  assign diff_s      = rem_shift_s - {1'b0, op_b_q};
  assign fits_s      = ~diff_s[WIDTH];
  assign rem_next_s  = fits_s ? diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
  assign quo_next_s  = {op_a_q[WIDTH-2:0], fits_s};

  // Single-cycle arithmetic on the popped operands; all results wrap.
  always_comb begin
    case (op_q)
      OP_ADD:  alu_s = op_a_q + op_b_q;
      OP_SUB:  alu_s = op_a_q - op_b_q;
      OP_MUL:  alu_s = op_a_q * op_b_q;
      default: alu_s = W_ZERO;
    endcase
  end

  // Next-state, stack and result logic.
  always_comb begin
    state_d    = state_q;
    stack_d    = stack_q;
    sp_d       = sp_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_d       = op_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    answer_d   = answer_q;
    ans_vld_d  = 1'b0;
    err_code_d = err_code_q;

    if (do_clear_s) begin
      state_d    = S_IDLE;
      sp_d       = SP_ZERO;
      answer_d   = W_ZERO;
      err_code_d = ERR_SYNTAX;
      cnt_d      = CNT_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s && is_num_s) begin
            if (sp_q == SP_FULL) begin
              state_d    = S_ERROR;
              err_code_d = ERR_OVF;
            end else begin
              stack_d[push_idx_s] = tok.tok_num;
              sp_d                = sp_q + SP_ONE;
            end
          end else if (accept_s) begin
            case (tok.tok_code)
              TK_ADD, TK_SUB, TK_MUL, TK_DIV: begin
                if (sp_q < SP_TWO) begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_UNF;
                end else begin
                  op_a_d = nos_s;
                  op_b_d = tos_s;
                  op_d   = tok.tok_code[1:0];
                  sp_d   = sp_q - SP_TWO;
                  if (tok.tok_code != TK_DIV) begin
                    state_d = S_EXEC;
                  end else if (tos_s == W_ZERO) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_DIV0;
                  end else begin
                    state_d = S_DIV;
                    rem_d   = W_ZERO;
                    cnt_d   = CNT_ZERO;
                  end
                end
              end
              TK_EQU: begin
                if (sp_q == SP_ONE) begin
                  answer_d  = tos_s;
                  ans_vld_d = 1'b1;
                  state_d   = S_DONE;
                end else if (sp_q == SP_ZERO) begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_UNF;
                end else begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_SYNTAX;
                end
              end
              default: state_d = S_IDLE;
            endcase
          end else begin
            state_d = S_IDLE;
          end
        end
        S_EXEC: begin
          stack_d[push_idx_s] = alu_s;
          sp_d                = sp_q + SP_ONE;
          state_d             = S_IDLE;
        end
        S_DIV: begin
          if (cnt_q == CNT_LAST) begin
            stack_d[push_idx_s] = op_a_q;
            sp_d                = sp_q + SP_ONE;
            state_d             = S_IDLE;
          end else begin
            op_a_d = quo_next_s;
            rem_d  = rem_next_s;
            cnt_d  = cnt_q + CNT_ONE;
          end
        end
        S_DONE, S_ERROR: state_d = state_q;
        default:         state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= W_ZERO;
      end
      sp_q       <= SP_ZERO;
      op_a_q     <= W_ZERO;
      op_b_q     <= W_ZERO;
      op_q       <= OP_MUL;
      rem_q      <= W_ZERO;
      cnt_q      <= CNT_ZERO;
      answer_q   <= W_ZERO;
      ans_vld_q  <= 1'b0;
      err_code_q <= ERR_SYNTAX;
    end else begin
      state_q    <= state_d;
      stack_q    <= stack_d;
      sp_q       <= sp_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      answer_q   <= answer_d;
      ans_vld_q  <= ans_vld_d;
      err_code_q <= err_code_d;
    end
  end

endmodule
